// File: rtl/mont_mul_r2.sv
// mont_mul_r2: radix-2 bit-serial Montgomery multiplier.
// result = in_a * in_b * 2^-WIDTH mod in_m, WIDTH+2 cycles per operation.
// Optional operand check is compiled in with `define MONT_MUL_INPUT_CHECK_EN.
`timescale 1ns/1ps

module mont_mul_r2 #(
    parameter int unsigned WIDTH = 381
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOP,
        SUB,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_r, b_r, m_r;
    logic [WIDTH+1:0] c;
    logic [IW-1:0]    i;
    logic [WIDTH+1:0] t1, t2, c_next;
    logic             chk_fail;
    logic             accept;

    assign accept = (state == IDLE) && start;

`ifdef MONT_MUL_INPUT_CHECK_EN
    logic err_r;

    assign chk_fail = ~in_m[0] | (in_a >= in_m) | (in_b >= in_m);
    assign err      = err_r;

    // Error flag: refreshed on every accepted start, held otherwise
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_r <= 1'b0;
        end else if (accept) begin
            err_r <= chk_fail;
        end
    end
`else
    assign chk_fail = 1'b0;
    assign err      = 1'b0;
`endif

    // One add-and-shift step: C + a[i]*b, then make it even with m, then halve
    always_comb begin
        t1     = c + (a_r[i] ? {2'b00, b_r} : '0);
        t2     = t1 + (t1[0] ? {2'b00, m_r} : '0);
        c_next = t2 >> 1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs; start is only looked at in IDLE
    always_comb begin
        state_next = state;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = chk_fail ? DONE : LOOP;
                end
            end
            LOOP: begin
                if (i == LAST) begin
                    state_next = SUB;
                end
            end
            SUB: begin
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, accumulator, bit counter and result register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_r    <= '0;
            b_r    <= '0;
            m_r    <= '0;
            c      <= '0;
            i      <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= in_a;
                        b_r <= in_b;
                        m_r <= in_m;
                        c   <= '0;
                        i   <= '0;
                        if (chk_fail) begin
                            result <= '0;
                        end
                    end
                end
                LOOP: begin
                    c <= c_next;
                    i <= i + IW'(1);
                end
                SUB: begin
                    if (c >= {2'b00, m_r}) begin
                        result <= WIDTH'(c - {2'b00, m_r});
                    end else begin
                        result <= c[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mul_r2.sv
// Directed self-checking bench for mont_mul_r2 (WIDTH=8 and WIDTH=381 instances).
`timescale 1ns/1ps

module tb_mont_mul_r2;

    logic         clk;
    logic         resetn;

    logic         start8;
    logic [7:0]   in_a8, in_b8, in_m8, result8;
    logic         done8, busy8, err8;

    logic         start_l;
    logic [380:0] in_a_l, in_b_l, in_m_l, result_l;
    logic         done_l, busy_l, err_l;

    int checks   = 0;
    int failures = 0;

    mont_mul_r2 #(.WIDTH(8)) u8 (
        .clk    (clk),
        .resetn (resetn),
        .start  (start8),
        .in_a   (in_a8),
        .in_b   (in_b8),
        .in_m   (in_m8),
        .result (result8),
        .done   (done8),
        .busy   (busy8),
        .err    (err8)
    );

    mont_mul_r2 #(.WIDTH(381)) u381 (
        .clk    (clk),
        .resetn (resetn),
        .start  (start_l),
        .in_a   (in_a_l),
        .in_b   (in_b_l),
        .in_m   (in_m_l),
        .result (result_l),
        .done   (done_l),
        .busy   (busy_l),
        .err    (err_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation: start sampled at the first tick (edge k), done at tick 10,
    // idle at tick 11. pulse_at re-asserts start mid-operation; scramble holds start and
    // changes the operand inputs every cycle through DONE.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] m, input logic [7:0] exp,
                       input int pulse_at, input bit scramble);
        in_a8  = a;
        in_b8  = b;
        in_m8  = m;
        start8 = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            check({tag, "_done"}, done8, (n == 10));
            check({tag, "_busy"}, busy8, (n <= 10));
            if (n == 10) check({tag, "_result"}, result8, exp);
            if (scramble) begin
                start8 = (n <= 10);
                in_a8  = 8'($urandom);
                in_b8  = 8'($urandom);
                in_m8  = 8'($urandom);
            end else begin
                start8 = (n == pulse_at);
            end
        end
        start8 = 1'b0;
    endtask

    initial begin
        bit saw_done;
        resetn  = 1'b0;
        start8  = 1'b0;
        in_a8   = '0;
        in_b8   = '0;
        in_m8   = '0;
        start_l = 1'b0;
        in_a_l  = '0;
        in_b_l  = '0;
        in_m_l  = '0;

        // Reset state
        tick();
        tick();
        check("rst_result8", result8, 0);
        check("rst_done8", done8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_err8", err8, 0);
        check("rst_result_l", result_l, 0);
        check("rst_busy_l", busy_l, 0);
        resetn = 1'b1;
        tick();

        // Directed WIDTH=8 vectors, m = 241, R^-1 = 225
        op8("a0f_b05", 8'h0F, 8'h05, 8'hF1, 8'h05, 0, 1'b0);
        op8("af0_bf0", 8'hF0, 8'hF0, 8'hF1, 8'hE1, 0, 1'b0);
        op8("a00_b77", 8'h00, 8'h77, 8'hF1, 8'h00, 0, 1'b0);
        op8("a01_b01", 8'h01, 8'h01, 8'hF1, 8'hE1, 0, 1'b0);
        op8("af0_b01", 8'hF0, 8'h01, 8'hF1, 8'h10, 0, 1'b0);
        op8("a02_b80", 8'h02, 8'h80, 8'hF1, 8'h01, 0, 1'b0);

        // Held start with operands changing every cycle, and a mid-operation start pulse
        op8("scramble", 8'h0F, 8'h05, 8'hF1, 8'h05, 0, 1'b1);
        op8("pulse", 8'hF0, 8'hF0, 8'hF1, 8'hE1, 4, 1'b0);

        // Reset asserted for one cycle at edge k+4 aborts the operation
        in_a8  = 8'h0F;
        in_b8  = 8'h05;
        in_m8  = 8'hF1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_result", result8, 0);
        saw_done = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done8) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        op8("after_abort", 8'h0F, 8'h05, 8'hF1, 8'h05, 0, 1'b0);

`ifdef MONT_MUL_INPUT_CHECK_EN
        // Even modulus: straight to DONE at k+1 with err set and result cleared
        in_a8  = 8'h0F;
        in_b8  = 8'h05;
        in_m8  = 8'hF0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("even_m_done", done8, 1);
        check("even_m_err", err8, 1);
        check("even_m_result", result8, 0);
        check("even_m_busy", busy8, 1);
        tick();
        check("even_m_idle", busy8, 0);
        check("even_m_err_hold", err8, 1);
        // Operand not below the modulus
        in_m8  = 8'hF1;
        in_a8  = 8'hF2;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("big_a_done", done8, 1);
        check("big_a_err", err8, 1);
        tick();
        // Valid start clears err on the accepting edge
        in_a8  = 8'h0F;
        start8 = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            start8 = 1'b0;
            if (n == 1) check("valid_err_clear", err8, 0);
            check("valid_done", done8, (n == 10));
            if (n == 10) check("valid_result", result8, 8'h05);
        end
`else
        // No check compiled in: an even modulus still runs the full sequence, err stays 0
        in_a8  = 8'h0F;
        in_b8  = 8'h05;
        in_m8  = 8'hF0;
        start8 = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            start8 = 1'b0;
            check("nochk_err", err8, 0);
            check("nochk_done", done8, (n == 10));
            check("nochk_busy", busy8, (n <= 10));
        end
`endif

        // WIDTH=381, m = 2^381-1 so R = 1 mod m; start held high throughout
        in_a_l  = 381'd2;
        in_b_l  = 381'd3;
        in_m_l  = '1;
        start_l = 1'b1;
        for (int n = 1; n <= 385; n++) begin
            tick();
            check("w381_done", done_l, (n == 383));
            check("w381_busy", busy_l, (n != 384));
            if (n == 383) check("w381_result", result_l, 381'd6);
        end
        start_l = 1'b0;
        // Second operation was accepted at edge k+384; done 382 ticks after that edge
        for (int n = 386; n <= 768; n++) begin
            tick();
            check("w381_b2b_done", done_l, (n == 767));
            if (n == 767) check("w381_b2b_result", result_l, 381'd6);
        end
        check("w381_b2b_idle", busy_l, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
